// File: rtl/arc4_crack_pkg.sv
// Shared types and constants for the arc4 key-search initiator and its plaintext checker.
package arc4_crack_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StStart    = 3'd1;
  localparam state_t StWaitBusy = 3'd2;
  localparam state_t StWaitDone = 3'd3;
  localparam state_t StRdLen    = 3'd4;
  localparam state_t StScan     = 3'd5;
  localparam state_t StNextKey  = 3'd6;
  localparam state_t StDone     = 3'd7;

  localparam logic [7:0] PT_LEN_ADDR = 8'd0;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/arc4_crack_if.sv
// arc4 start/ready handshake plus the plaintext memory port that the cracker arbitrates.
interface arc4_crack_if;
  logic        a4_en;
  logic        a4_rdy;
  logic [23:0] a4_key;
  logic [7:0]  a4_pt_addr;
  logic [7:0]  a4_pt_wrdata;
  logic        a4_pt_wren;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;
  logic [7:0]  pt_rddata;

  modport master (
    output a4_en, a4_key, pt_addr, pt_wrdata, pt_wren,
    input  a4_rdy, a4_pt_addr, a4_pt_wrdata, a4_pt_wren, pt_rddata
  );

  modport slave (
    input  a4_en, a4_key, pt_addr, pt_wrdata, pt_wren,
    output a4_rdy, a4_pt_addr, a4_pt_wrdata, a4_pt_wren, pt_rddata
  );
endinterface

// File: rtl/arc4_crack_pt_checker.sv
// Reads the length byte then scans the plaintext one byte per cycle against the printable range.
module arc4_crack_pt_checker
  import arc4_crack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] rddata_i,
  output logic [7:0] addr_o,
  output logic       len_ok_o,
  output logic       done_o,
  output logic       pass_o
);

  localparam logic [1:0] ChkIdle = 2'd0;
  localparam logic [1:0] ChkLen  = 2'd1;
  localparam logic [1:0] ChkScan = 2'd2;

  logic [1:0] cst_q, cst_d;
  // Ninth bit lets the pipeline present "addr 256" while byte 255 is checked, with no wrap.
  logic [8:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;

  always_comb begin
    cst_d    = cst_q;
    addr_d   = addr_q;
    len_d    = len_q;
    len_ok_o = 1'b0;
    done_o   = 1'b0;
    pass_o   = 1'b0;
    case (cst_q)
      ChkIdle: begin
        addr_d = {1'b0, PT_LEN_ADDR};
        if (start_i) begin
          cst_d  = ChkLen;
          addr_d = 9'd1;
        end
      end
      ChkLen: begin
        if (rddata_i == 8'd0) begin
          done_o = 1'b1;
          cst_d  = ChkIdle;
          addr_d = 9'd0;
        end else begin
          len_ok_o = 1'b1;
          len_d    = rddata_i;
          addr_d   = addr_q + 9'd1;
          cst_d    = ChkScan;
        end
      end
      ChkScan: begin
        if (!is_print(rddata_i)) begin
          done_o = 1'b1;
          cst_d  = ChkIdle;
          addr_d = 9'd0;
        end else if ((addr_q - 9'd1) == {1'b0, len_q}) begin
          done_o = 1'b1;
          pass_o = 1'b1;
          cst_d  = ChkIdle;
          addr_d = 9'd0;
        end else begin
          addr_d = addr_q + 9'd1;
        end
      end
      default: begin
        cst_d  = ChkIdle;
        addr_d = 9'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst_q  <= ChkIdle;
      addr_q <= 9'd0;
      len_q  <= 8'd0;
    end else begin
      cst_q  <= cst_d;
      addr_q <= addr_d;
      len_q  <= len_d;
    end
  end

  assign addr_o = addr_q[7:0];

endmodule

// File: rtl/arc4_crack.sv
// Key-search initiator: steps arc4 through keys and accepts the first one whose plaintext is printable.
module arc4_crack
  import arc4_crack_pkg::*;
#(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_MAX   = 24'hFFFFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic         rdy_o,
  output logic         key_valid_o,
  output logic [23:0]  key_o,
  arc4_crack_if.master a4_if
);

  state_t      state_q, state_d;
  logic [23:0] a4_key_q, a4_key_d;
  logic [23:0] key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic        a4_en;
  logic        chk_start, chk_len_ok, chk_done, chk_pass;
  logic [7:0]  chk_addr;
  logic        arc4_owns_pt;

  arc4_crack_pt_checker u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (chk_start),
    .rddata_i (a4_if.pt_rddata),
    .addr_o   (chk_addr),
    .len_ok_o (chk_len_ok),
    .done_o   (chk_done),
    .pass_o   (chk_pass)
  );

  assign chk_start = (state_q == StRdLen);

  always_comb begin
    state_d     = state_q;
    a4_key_d    = a4_key_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    a4_en       = 1'b0;
    case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d     = StStart;
          a4_key_d    = KEY_START;
          key_valid_d = 1'b0;
        end
      end
      StStart: begin
        if (a4_if.a4_rdy) begin
          a4_en   = 1'b1;
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: if (!a4_if.a4_rdy) state_d = StWaitDone;
      StWaitDone: if (a4_if.a4_rdy) state_d = StRdLen;
      StRdLen: begin
        // A zero length byte is a reject before any scan starts.
        if (chk_done) begin
          state_d = (a4_key_q == KEY_MAX) ? StDone : StNextKey;
        end else if (chk_len_ok) begin
          state_d = StScan;
        end
      end
      StScan: begin
        if (chk_done) begin
          if (chk_pass) begin
            key_d       = a4_key_q;
            key_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            state_d = (a4_key_q == KEY_MAX) ? StDone : StNextKey;
          end
        end
      end
      StNextKey: begin
        a4_key_d = a4_key_q + 24'd1;
        state_d  = StStart;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a4_key_q    <= KEY_START;
      key_q       <= 24'd0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a4_key_q    <= a4_key_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign arc4_owns_pt = (state_q == StStart) || (state_q == StWaitBusy) ||
                        (state_q == StWaitDone);

  assign a4_if.pt_addr   = arc4_owns_pt ? a4_if.a4_pt_addr   : chk_addr;
  assign a4_if.pt_wrdata = arc4_owns_pt ? a4_if.a4_pt_wrdata : 8'd0;
  assign a4_if.pt_wren   = arc4_owns_pt ? a4_if.a4_pt_wren   : 1'b0;
  assign a4_if.a4_en     = a4_en;
  assign a4_if.a4_key    = a4_key_q;

  assign rdy_o       = (state_q == StIdle);
  assign key_valid_o = key_valid_q;
  assign key_o       = key_q;

endmodule
